// File: rtl/rf_write_arbiter_pkg.sv
// rf_arb_pkg: shared types and helpers for the register-file write-port arbiter.
package rf_arb_pkg;
    localparam int REG_COUNT = 32;
    typedef enum logic {IDLE, LOCKED} arb_state_t;
    typedef logic [$clog2(REG_COUNT)-1:0] reg_addr_t;
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback requester bundle and arbitrated register-file write port.
interface rf_write_arbiter_if #(parameter int N = 32, parameter int NREQ = 3);
    import rf_arb_pkg::*;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         lock;
    logic [5*NREQ-1:0]       waddr;
    logic [N*NREQ-1:0]       wdata;
    logic [NREQ-1:0]         gnt;
    logic                    rf_we;
    reg_addr_t               rf_rw;
    logic [N-1:0]            rf_wd;
    logic [$clog2(NREQ)-1:0] owner;
    logic                    locked;
    modport master(output req, lock, waddr, wdata, input gnt, rf_we, rf_rw, rf_wd, owner, locked);
    modport slave(input req, lock, waddr, wdata, output gnt, rf_we, rf_rw, rf_wd, owner, locked);
endinterface

// File: rtl/rf_write_arbiter_rr_picker.sv
// rr_picker: one-hot select of the first request at or after ptr, wrapping upward.
// RFARB_FIXED_PRIO_EN turns it into a lowest-index-wins priority picker and ignores ptr.
module rr_picker #(parameter int NREQ = 3) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);
    // Scan from the farthest candidate down so the nearest one is written last and wins.
    always_comb begin
        gnt = '0;
`ifdef RFARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[i]) gnt = NREQ'(1) << i;
`else
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) gnt = NREQ'(1) << ((int'(ptr) + k) % NREQ);
`endif
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port with locked bursts.
// RFARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rf_write_arbiter import rf_arb_pkg::*; #(
    parameter int N        = 32,
    parameter int NREQ     = 3,
    parameter int MAX_LOCK = 8
) (
    input logic              clk,
    input logic              reset,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);
    arb_state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n, own, own_n, idx, widx;
    logic [CW-1:0] cnt, cnt_n;
    logic [NREQ-1:0] pick, gnt;
    rr_picker #(.NREQ(NREQ)) u_pick (.req(bus.req), .ptr(ptr), .gnt(pick));
    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) idx = PW'(i);
    end
    always_comb begin
        gnt = '0;
        if (!reset) gnt = (state == IDLE) ? pick : (NREQ'(bus.req[own]) << own);
    end
    assign widx = (state == IDLE) ? idx : own;
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        own_n   = own;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (|pick) begin
                ptr_n = PW'(wrap_inc(int'(idx), NREQ));
                if (bus.lock[idx] && MAX_LOCK > 1) begin
                    state_n = LOCKED;
                    own_n   = idx;
                    cnt_n   = CW'(1);
                end
            end
        end else if (bus.req[own]) begin
            cnt_n = cnt + CW'(1);
            // The grant that brings the count to MAX_LOCK is the last one of the burst.
            if (!bus.lock[own] || cnt == CW'(MAX_LOCK - 1)) begin
                state_n = IDLE;
                ptr_n   = PW'(wrap_inc(int'(own), NREQ));
                cnt_n   = '0;
            end
        end else if (!bus.lock[own]) begin
            state_n = IDLE;
            ptr_n   = PW'(wrap_inc(int'(own), NREQ));
            cnt_n   = '0;
        end
    end
`ifdef RFARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk)
        ptr <= reset ? '0 : ptr_n;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            own       <= '0;
            cnt       <= '0;
            bus.rf_we <= 1'b0;
            bus.rf_rw <= '0;
            bus.rf_wd <= '0;
        end else begin
            state     <= state_n;
            own       <= own_n;
            cnt       <= cnt_n;
            bus.rf_we <= |gnt;
            if (|gnt) begin
                bus.rf_rw <= bus.waddr[widx*5 +: 5];
                bus.rf_wd <= bus.wdata[widx*N +: N];
            end
        end
    end
    assign bus.gnt    = gnt;
    assign bus.owner  = own;
    assign bus.locked = (state == LOCKED);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of round-robin grants, locked bursts and reset.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;
    localparam int N = 32, NREQ = 3, MAX_LOCK = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [N-1:0] rf_model [REG_COUNT];
    rf_write_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
    rf_write_arbiter #(.N(N), .NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk)
        if (bus.rf_we) rf_model[bus.rf_rw] <= bus.rf_wd;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [2:0] r, input logic [2:0] l);
        bus.req = r;
        bus.lock = l;
        #1;
    endtask
    initial begin
        bus.waddr = {5'd5, 5'd4, 5'd3};
        bus.wdata = {32'h0C, 32'h0B, 32'h0A};
        drive(3'b111, 3'b000);
        chk("gnt_in_reset", bus.gnt, 3'b000);
        tick;
        tick;
        chk("rst_we", bus.rf_we, 1'b0);
        chk("rst_rw", bus.rf_rw, 5'd0);
        chk("rst_wd", bus.rf_wd, 32'h0);
        chk("rst_locked", bus.locked, 1'b0);
        chk("rst_owner", bus.owner, 2'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(3'b000, 3'b000);
            chk("idle_gnt", bus.gnt, 3'b000);
            tick;
            chk("idle_we", bus.rf_we, 1'b0);
        end
        chk("idle_rw", bus.rf_rw, 5'd0);
        chk("idle_wd", bus.rf_wd, 32'h0);
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 3'b000);
            chk("rr_gnt", bus.gnt, 3'b001 << (k % 3));
            tick;
            chk("rr_we", bus.rf_we, 1'b1);
            chk("rr_rw", bus.rf_rw, 64'(3 + k % 3));
            chk("rr_wd", bus.rf_wd, 64'(32'h0A + k % 3));
        end
        drive(3'b000, 3'b000);
        tick;
        chk("drop_we", bus.rf_we, 1'b0);
        chk("drop_rw_hold", bus.rf_rw, 5'd5);
        bus.wdata[2*N +: N] = 32'hD1;
        drive(3'b100, 3'b100);
        chk("lk1_gnt", bus.gnt, 3'b100);
        tick;
        chk("lk1_locked", bus.locked, 1'b1);
        chk("lk1_owner", bus.owner, 2'd2);
        chk("lk1_wd", bus.rf_wd, 32'hD1);
        bus.wdata[2*N +: N] = 32'hD2;
        drive(3'b101, 3'b100);
        chk("lk2_gnt", bus.gnt, 3'b100);
        tick;
        chk("lk2_we", bus.rf_we, 1'b1);
        chk("lk2_wd", bus.rf_wd, 32'hD2);
        bus.wdata[2*N +: N] = 32'hD3;
        drive(3'b101, 3'b000);
        chk("lk3_gnt", bus.gnt, 3'b100);
        tick;
        chk("lk3_wd", bus.rf_wd, 32'hD3);
        chk("lk3_rw", bus.rf_rw, 5'd5);
        chk("lk3_released", bus.locked, 1'b0);
        drive(3'b001, 3'b000);
        chk("after_lock_gnt", bus.gnt, 3'b001);
        tick;
        chk("after_lock_rw", bus.rf_rw, 5'd3);
        for (int k = 0; k < 8; k++) begin
            drive(3'b011, 3'b010);
            chk("max_gnt", bus.gnt, 3'b010);
            tick;
            chk("max_rw", bus.rf_rw, 5'd4);
            chk("max_locked", bus.locked, (k < 7) ? 1'b1 : 1'b0);
        end
        drive(3'b011, 3'b010);
        chk("max_next_gnt", bus.gnt, 3'b001);
        tick;
        chk("max_next_locked", bus.locked, 1'b0);
        drive(3'b100, 3'b000);
        chk("ptr_prep_gnt", bus.gnt, 3'b100);
        tick;
        bus.waddr[4:0] = 5'd7;
        bus.waddr[9:5] = 5'd7;
        bus.wdata[0 +: N] = 32'h11;
        bus.wdata[N +: N] = 32'h22;
        drive(3'b011, 3'b000);
        chk("same_gnt0", bus.gnt, 3'b001);
        tick;
        chk("same_rw0", bus.rf_rw, 5'd7);
        chk("same_wd0", bus.rf_wd, 32'h11);
        drive(3'b010, 3'b000);
        chk("same_gnt1", bus.gnt, 3'b010);
        tick;
        chk("same_wd1", bus.rf_wd, 32'h22);
        drive(3'b000, 3'b000);
        tick;
        chk("rf_reg7", rf_model[7], 32'h22);
        drive(3'b100, 3'b100);
        chk("rl_gnt", bus.gnt, 3'b100);
        tick;
        chk("rl_locked", bus.locked, 1'b1);
        drive(3'b000, 3'b100);
        chk("hold_gnt", bus.gnt, 3'b000);
        tick;
        chk("hold_locked", bus.locked, 1'b1);
        chk("hold_we", bus.rf_we, 1'b0);
        reset = 1'b1;
        drive(3'b100, 3'b100);
        chk("rl_reset_gnt", bus.gnt, 3'b000);
        tick;
        chk("rl_reset_we", bus.rf_we, 1'b0);
        chk("rl_reset_locked", bus.locked, 1'b0);
        chk("rl_reset_owner", bus.owner, 2'd0);
        reset = 1'b0;
        drive(3'b001, 3'b000);
        chk("post_reset_gnt", bus.gnt, 3'b001);
        tick;
        chk("post_reset_we", bus.rf_we, 1'b1);
        chk("post_reset_wd", bus.rf_wd, 32'h11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we/rw/wd, written on the clock's low phase) between NREQ writeback sources: ALU, load unit and the modular-exponentiation unit of the RSA decryption path.
- Grants one requester per cycle using round-robin arbitration.
- Supports locked bursts, so a multi-word result from the exponentiation unit lands in consecutive cycles.
- Write-port outputs are registered, giving one cycle of latency, so the register file samples stable values on the falling edge.

Parameters:
- N, 32, data width; matches the register file.
- NREQ, 3, number of writeback requesters, 2..8.
- MAX_LOCK, 8, maximum consecutive cycles one requester may hold a lock.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request; held until granted.
- lock  input  NREQ  requester asks to keep the port after its current grant.
- waddr  input  5*NREQ  destination register; slice i belongs to requester i.
- wdata  input  N*NREQ  write data; slice i belongs to requester i.
- gnt  output  NREQ  one-hot grant, combinational, same cycle as the accepted req.
- rf_we  output  1  registered write enable to the register file.
- rf_rw  output  5  registered destination register.
- rf_wd  output  N  registered write data.
- owner  output  $clog2(NREQ)  index of the current lock holder; valid in LOCKED only.
- locked  output  1  high while in LOCKED.

Behaviour:
- Reset (synchronous):
  - rf_we=0, rf_rw=0, rf_wd=0, owner=0, locked=0.
  - Round-robin pointer = 0, lock counter = 0, state = IDLE.
  - gnt=0 during any cycle in which reset is high.
- Handshake:
  - A transfer occurs in cycle t when req[i] & gnt[i].
  - Cycle t+1: rf_we=1, rf_rw=waddr[i], rf_wd=wdata[i].
  - If there is no transfer in t, rf_we=0 in t+1; rf_rw and rf_wd hold their last values.
  - The requester may change its waddr/wdata or drop req after the grant cycle.
- IDLE/ARB state:
  - gnt goes to the first asserted req at or after the pointer, scanning upward with wrap from NREQ-1 to 0.
  - After a grant to i, the pointer becomes (i+1) mod NREQ.
  - If lock[i] was high in the grant cycle: go to LOCKED, owner=i, counter=1.
- LOCKED state:
  - Only owner may be granted; all other gnt bits are 0.
  - gnt[owner]=req[owner]; a cycle without req keeps the lock but produces no write.
  - Each grant increments the counter.
  - Return to IDLE when lock[owner] is low at a grant, or lock[owner] is low with no req, or the counter reaches MAX_LOCK (a forced release after that grant).
  - On exit, the pointer becomes (owner+1) mod NREQ.
- Simultaneous writes to the same register from different requesters:
  - Serialised in grant order; the later write wins.
  - No merging or dropping.
- Writes to register 0 are passed through unchanged (the register file has no hardwired zero).
- Reset mid-LOCKED or mid-write:
  - Pending output write is cancelled (rf_we=0 next cycle).
  - Lock is dropped; requesters must re-request.
- No starvation: each requester waits at most (NREQ-1)*MAX_LOCK grants.

Optional Feature:
- Macro: RFARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; pointer logic removed; LOCKED and MAX_LOCK unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package rf_arb_pkg:
  - typedef arb_state_t {IDLE, LOCKED}.
  - typedef reg_addr_t = logic [4:0].
  - Constant REG_COUNT = 32.
- One sub-module, rr_picker: combinational one-hot round-robin select (req, pointer -> gnt); selected to fixed priority under RFARB_FIXED_PRIO_EN.

Test Plan:
- Reset, then req=3'b000 for 5 cycles -> gnt=0, rf_we=0, rf_rw=0, rf_wd=0.
- req=3'b111 held 6 cycles, waddr={5,4,3}, wdata={C,B,A} -> grants 0,1,2,0,1,2; rf_rw sequence 3,4,5,... starting one cycle after the first grant.
- req[2]=1 with lock[2] high for 3 grants, while req[0]=1 -> gnt[0]=0 throughout; locked=1, owner=2; writes 3 words on consecutive cycles; gnt[0] in the cycle after release.
- MAX_LOCK=8, lock[1] held for 20 cycles with req[0] and req[1] both high -> forced release after 8 grants; requester 0 granted next.
- Requesters 0 and 1 both write register 7, data 0x11 and 0x22 -> rf_wd=0x11 then 0x22; final register-file content 0x22.
- Reset asserted in LOCKED with a grant in the same cycle -> gnt=0, next-cycle rf_we=0, locked=0, state=IDLE.
